// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: UART command sequencer driving CPU run/step/halt and streaming a word dump to TX
module uart_debug_ctrl #(
  parameter int DUMP_WORDS = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              rd,
  input  logic              tx_full,
  output logic [7:0]        tx_data,
  output logic              wr,
  output logic              cpu_run,
  output logic              cpu_step,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [31:0]       dump_data
);
  typedef enum logic [2:0] {IDLE, DECODE, STEP, RUN, FETCH, SEND, TERM, ERR} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_WORDS - 1);
  localparam logic [7:0] C_DUMP = 8'h64;
  localparam logic [7:0] C_STEP = 8'h73;
  localparam logic [7:0] C_CONT = 8'h63;
  localparam logic [7:0] C_HALT = 8'h68;
  state_t state, nxt;
  logic [7:0] cmd;
  logic [31:0] sh;
  logic [1:0] idx;
  logic fw;
  logic [ADDR_W-1:0] cnt;
  assign dump_addr = cnt;
  // state register; reset aborts any command in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // handshakes are gated by FIFO status so rd/wr never fire against empty/full
  always_comb begin
    rd = !reset && !rx_empty && (state == IDLE || state == RUN);
    wr = !reset && !tx_full && (state == SEND || state == TERM || state == ERR);
    tx_data = state == SEND ? sh[7:0] : state == TERM ? 8'h0A : state == ERR ? 8'h3F : 8'h00;
    cpu_run = state == RUN;
    cpu_step = state == STEP;
    nxt = state;
    case (state)
      IDLE:    nxt = rd ? DECODE : IDLE;
      DECODE:  nxt = cmd == C_DUMP ? FETCH : cmd == C_STEP ? STEP : cmd == C_CONT ? RUN :
                     cmd == C_HALT ? IDLE : ERR;
      STEP:    nxt = FETCH;
      RUN:     nxt = (cpu_halted || (rd && rx_data == C_HALT)) ? FETCH : RUN;
      FETCH:   nxt = fw ? SEND : FETCH;
      SEND:    nxt = (wr && idx == 2'd3) ? (cnt == LAST ? TERM : FETCH) : SEND;
      TERM:    nxt = wr ? IDLE : TERM;
      ERR:     nxt = wr ? IDLE : ERR;
      default: nxt = IDLE;
    endcase
  end
  // datapath: command capture, fetch wait, LSB-first shift register, word counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cmd <= 8'h00;
      sh <= 32'h0;
      idx <= 2'd0;
      fw <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && rd) cmd <= rx_data;
      fw <= state == FETCH && !fw;
      if (state == FETCH && fw) begin
        sh <= dump_data;
        idx <= 2'd0;
      end else if (state == SEND && wr) begin
        sh <= sh >> 8;
        idx <= idx + 2'd1;
        if (idx == 2'd3 && cnt != LAST) cnt <= cnt + 1'b1;
      end
      if (state == TERM && wr) cnt <= '0;
    end
endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb_uart_debug_ctrl: scoreboard bench for the UART debug command sequencer
module tb_uart_debug_ctrl;
  logic clk = 1'b0;
  logic reset, rx_empty, rd, tx_full, wr, cpu_run, cpu_step, cpu_halted;
  logic [7:0] rx_data, tx_data;
  logic [4:0] dump_addr;
  logic [31:0] dump_data = 32'h0;
  logic [7:0] rxm [64];
  int rh = 0, rt = 0;
  byte unsigned expq [$];
  int compared = 0, mism = 0;
  int rd_n = 0, run_n = 0, step_n = 0, bad_n = 0, nb = 0;

  uart_debug_ctrl #(.DUMP_WORDS(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rd(rd),
    .tx_full(tx_full), .tx_data(tx_data), .wr(wr), .cpu_run(cpu_run), .cpu_step(cpu_step),
    .cpu_halted(cpu_halted), .dump_addr(dump_addr), .dump_data(dump_data)
  );

  always #5 clk = ~clk;

  assign rx_empty = (rh == rt);
  assign rx_data = rxm[rh % 64];

  // debug read port: data follows the address by one cycle
  always @(posedge clk) dump_data <= 32'hA0B0C000 + 32'(dump_addr);
  // RX FIFO pop
  always @(posedge clk) if (rd) rh <= rh + 1;

  // monitor: activity counters and TX scoreboard
  always @(negedge clk) begin
    if (rd) rd_n++;
    if (cpu_run) run_n++;
    if (cpu_step) step_n++;
    if ((rd && rx_empty) || (wr && tx_full) || (cpu_run && cpu_step)) bad_n++;
    if (wr) begin
      nb++;
      compared++;
      if (expq.size() == 0) begin
        mism++;
        $display("FAIL tx_byte got %02h expected none", tx_data);
      end else begin
        automatic byte unsigned e = expq.pop_front();
        if (tx_data !== e) begin
          mism++;
          $display("FAIL tx_byte got %02h expected %02h", tx_data, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mism++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rxm[rt % 64] = b;
    rt++;
  endtask

  task automatic exp_words(input int n);
    for (int w = 0; w < n; w++) begin
      expq.push_back(8'(w));
      expq.push_back(8'hC0);
      expq.push_back(8'hB0);
      expq.push_back(8'hA0);
    end
  endtask

  task automatic exp_dump();
    exp_words(32);
    expq.push_back(8'h0A);
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 3000 && expq.size() != 0; i++) @(negedge clk);
    chk(n, expq.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_run(input string n);
    int i;
    for (i = 0; i < 20 && !cpu_run; i++) @(negedge clk);
    chk(n, cpu_run, 1);
  endtask

  task automatic wait_bytes(input string n, input int target);
    int i;
    for (i = 0; i < 3000 && nb < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk(n, nb, target);
  endtask

  initial begin
    int r0, u0, s0, n0;
    logic ss;
    reset = 1'b1;
    tx_full = 1'b0;
    cpu_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", rd, 0);
    chk("reset_wr", wr, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_run", cpu_run, 0);
    chk("reset_step", cpu_step, 0);
    chk("reset_addr", dump_addr, 0);
    reset = 1'b0;

    // plain dump
    r0 = rd_n; u0 = run_n; s0 = step_n;
    exp_dump();
    @(posedge clk); #1 push(8'h64);
    drain("dump_drain");
    chk("dump_rd_count", rd_n - r0, 1);
    chk("dump_run_count", run_n - u0, 0);
    chk("dump_step_count", step_n - s0, 0);

    // dump with TX stall on byte 2 of word 3
    n0 = nb;
    exp_dump();
    @(posedge clk); #1 push(8'h64);
    wait_bytes("stall_reach", n0 + 14);
    @(posedge clk); #1 tx_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr", wr, 0);
      chk("stall_tx_data", tx_data, 8'hB0);
    end
    @(posedge clk); #1 tx_full = 1'b0;
    drain("stall_drain");

    // unknown command
    r0 = rd_n; u0 = run_n; s0 = step_n;
    expq.push_back(8'h3F);
    @(posedge clk); #1 push(8'h41);
    drain("err_drain");
    chk("err_rd_count", rd_n - r0, 1);
    chk("err_run_count", run_n - u0, 0);
    chk("err_step_count", step_n - s0, 0);

    // run until cpu_halted, which rises in the tenth run cycle
    u0 = run_n;
    exp_dump();
    @(posedge clk); #1 push(8'h63);
    wait_run("cont_run_seen");
    repeat (9) @(posedge clk);
    #1 cpu_halted = 1'b1;
    drain("cont_drain");
    chk("cont_run_cycles", run_n - u0, 10);
    cpu_halted = 1'b0;

    // run, junk byte discarded, 'h' halts
    r0 = rd_n; u0 = run_n;
    exp_dump();
    @(posedge clk); #1 push(8'h63);
    wait_run("halt_run_seen");
    @(posedge clk); #1 push(8'h78);
    repeat (3) @(posedge clk);
    #1 push(8'h68);
    drain("halt_drain");
    chk("halt_run_cycles", run_n - u0, 5);
    chk("halt_rd_count", rd_n - r0, 3);

    // step, then reset during word 5
    s0 = step_n; n0 = nb; ss = 1'b0;
    exp_words(5);
    expq.push_back(8'h05);
    @(posedge clk); #1 push(8'h73);
    for (int i = 0; i < 50 && !wr; i++) begin
      @(negedge clk);
      if (cpu_step) ss = 1'b1;
    end
    chk("step_before_dump", ss, 1);
    wait_bytes("step_reach", n0 + 21);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("abort_rd", rd, 0);
    chk("abort_wr", wr, 0);
    chk("abort_tx_data", tx_data, 0);
    chk("abort_run", cpu_run, 0);
    chk("abort_step", cpu_step, 0);
    chk("abort_addr", dump_addr, 0);
    chk("abort_bytes", expq.size(), 0);
    chk("step_count", step_n - s0, 1);
    @(posedge clk); #1 reset = 1'b0;
    exp_dump();
    @(posedge clk); #1 push(8'h64);
    drain("restart_drain");

    chk("protocol_violations", bad_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
